// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with a one-entry skid buffer, valid/ready handshake and flush.
module id_ex_pipe #(
    parameter int XLEN = 32,
    parameter int ACW  = 3,
    parameter int RAW  = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FlushE,
    input  logic            ValidD,
    output logic            ReadyD,
    input  logic            RegWriteD,
    input  logic            ResultSrcD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [ACW-1:0]  ALUControlD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [RAW-1:0]  Rs1D,
    input  logic [RAW-1:0]  Rs2D,
    input  logic [RAW-1:0]  RdD,
    output logic            ValidE,
    input  logic            ReadyE,
    output logic            RegWriteE,
    output logic            ResultSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [ACW-1:0]  ALUControlE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [RAW-1:0]  Rs1E,
    output logic [RAW-1:0]  Rs2E,
    output logic [RAW-1:0]  RdE
);
    localparam int PW = 5 + ACW + 5 * XLEN + 3 * RAW;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_n;
    logic [PW-1:0] d_pay, m_pay, s_pay;
    logic load_m, load_s, m_from_s, accept, retire;
    logic rw_m, mw_m, br_m;
    assign d_pay = {RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD, ALUControlD,
                    PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD};
    assign {rw_m, ResultSrcE, mw_m, br_m, ALUSrcE, ALUControlE,
            PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE} = m_pay;
    assign ValidE    = (state != EMPTY);
    // a bubble must never commit architectural side effects
    assign RegWriteE = rw_m & ValidE;
    assign MemWriteE = mw_m & ValidE;
    assign BranchE   = br_m & ValidE;
    assign accept    = ValidD & ReadyD;
    assign retire    = ValidE & ReadyE;
    always_comb begin
        state_n  = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (FlushE) state_n = EMPTY;
        else case (state)
            EMPTY: if (accept) begin state_n = ONE; load_m = 1'b1; end
            ONE: begin
                if (accept && retire) load_m = 1'b1;
                else if (accept) begin state_n = FULL; load_s = 1'b1; end
                else if (retire) state_n = EMPTY;
            end
            FULL: if (retire) begin state_n = ONE; load_m = 1'b1; m_from_s = 1'b1; end
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= EMPTY;
            ReadyD <= 1'b1;
        end else begin
            state  <= state_n;
            ReadyD <= (state_n != FULL);
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pay <= '0;
            s_pay <= '0;
        end else begin
            if (load_m) m_pay <= m_from_s ? s_pay : d_pay;
            if (load_s) s_pay <= d_pay;
        end
    end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: vector table, directed corner cases and a queue scoreboard for id_ex_pipe (XLEN=64, ACW=4).
module tb_id_ex_pipe;
    typedef struct packed {
        logic rw, rs, mw, br, as;
        logic [3:0] alu;
        logic [63:0] pc, pc4, rd1, rd2, imm;
        logic [4:0] r1, r2, rd;
    } pay_t;
    typedef struct {
        logic vd, re, fl;
        logic [63:0] pc;
        logic ev, er, cp;
        logic [63:0] epc;
    } vec_t;
    logic CLK = 0, RST_N = 0, FlushE = 0, ValidD = 0, ReadyE = 0, ReadyD, ValidE;
    logic RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD;
    logic RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
    logic [3:0] ALUControlD, ALUControlE;
    logic [63:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD, PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    pay_t din = '0, dout, held;
    pay_t q[$];
    logic hold_v = 0;
    int checks = 0, errors = 0;
    vec_t vt[16];
    assign {RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD, ALUControlD,
            PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD} = din;
    assign dout = {RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE,
                   PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE};

    id_ex_pipe #(.XLEN(64), .ACW(4), .RAW(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .FlushE(FlushE), .ValidD(ValidD), .ReadyD(ReadyD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidE(ValidE), .ReadyE(ReadyE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    always #5 CLK = ~CLK;

    function automatic pay_t mk(input logic [63:0] pc);
        pay_t p;
        p.pc = pc;
        p.pc4 = pc + 64'd4;
        p.rd1 = {pc[31:0] ^ 32'hdeadbeef, pc[31:0]};
        p.rd2 = ~pc;
        p.imm = pc * 64'd3;
        p.alu = pc[5:2];
        {p.rw, p.rs, p.mw, p.br, p.as} = pc[6:2] ^ 5'b10101;
        p.r1 = pc[6:2];
        p.r2 = pc[7:3];
        p.rd = pc[8:4];
        return p;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk_pay(input string n, input pay_t a, input pay_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // runs between negedge and posedge; model decides transfers from its own occupancy
    task automatic sb_update();
        logic acc, ret;
        chk("valid_model", 64'(ValidE), 64'(q.size() > 0));
        chk("ready_model", 64'(ReadyD), 64'(q.size() < 2));
        if (!ValidE) chk("bubble_ctrl", 64'({RegWriteE, MemWriteE, BranchE}), 64'd0);
        if (hold_v) chk_pay("hold_stable", dout, held);
        hold_v = ValidE && !ReadyE && !FlushE;
        held = dout;
        acc = ValidD && (q.size() < 2);
        ret = ReadyE && (q.size() > 0);
        if (FlushE) q.delete();
        else begin
            if (ret) chk_pay("order", dout, q.pop_front());
            if (acc) q.push_back(din);
        end
    endtask

    task automatic drive(input logic vd, input pay_t p, input logic re, input logic fl);
        @(negedge CLK);
        ValidD = vd; din = p; ReadyE = re; FlushE = fl;
        #1 sb_update();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        pay_t p;
        //       vd re fl  pc        ev er cp epc
        vt[0]  = '{1, 1, 0, 64'h0,   1, 1, 1, 64'h0};
        vt[1]  = '{1, 1, 0, 64'h4,   1, 1, 1, 64'h4};
        vt[2]  = '{1, 1, 0, 64'h8,   1, 1, 1, 64'h8};
        vt[3]  = '{0, 1, 0, 64'h0,   0, 1, 0, 64'h0};
        vt[4]  = '{1, 0, 0, 64'h100, 1, 1, 1, 64'h100};
        vt[5]  = '{1, 0, 0, 64'h104, 1, 0, 1, 64'h100};
        vt[6]  = '{1, 0, 0, 64'h108, 1, 0, 1, 64'h100};
        vt[7]  = '{0, 1, 0, 64'h0,   1, 1, 1, 64'h104};
        vt[8]  = '{0, 1, 0, 64'h0,   0, 1, 0, 64'h0};
        vt[9]  = '{1, 0, 0, 64'h10,  1, 1, 1, 64'h10};
        vt[10] = '{1, 0, 0, 64'h14,  1, 0, 1, 64'h10};
        vt[11] = '{1, 1, 1, 64'h200, 0, 1, 0, 64'h0};
        vt[12] = '{0, 1, 0, 64'h0,   0, 1, 0, 64'h0};
        vt[13] = '{1, 0, 0, 64'h20,  1, 1, 1, 64'h20};
        vt[14] = '{1, 1, 1, 64'h24,  0, 1, 0, 64'h0};
        vt[15] = '{0, 1, 0, 64'h0,   0, 1, 0, 64'h0};
        #12;
        chk("rst_valid", 64'(ValidE), 64'd0);
        chk("rst_ready", 64'(ReadyD), 64'd1);
        chk_pay("rst_outputs", dout, '0);
        @(negedge CLK);
        RST_N = 1;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].vd, mk(vt[i].pc), vt[i].re, vt[i].fl);
            chk($sformatf("vec%0d_valid", i), 64'(ValidE), 64'(vt[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(ReadyD), 64'(vt[i].er));
            if (vt[i].cp) chk($sformatf("vec%0d_pc", i), PCE, vt[i].epc);
            if (ValidE) chk($sformatf("vec%0d_no200", i), 64'(PCE == 64'h200), 64'd0);
        end
        p = mk(64'h300);
        p.rd1 = 64'hFFFF_0000_1234_5678;
        p.alu = 4'hA;
        drive(1, p, 1, 0);
        chk("wide_rd1", RD1E, 64'hFFFF_0000_1234_5678);
        chk("wide_alu", 64'(ALUControlE), 64'hA);
        drive(0, '0, 1, 0);
        drive(1, mk(64'h400), 0, 0);
        drive(1, mk(64'h404), 0, 0);
        #2;
        RST_N = 0;
        ValidD = 0;
        #1;
        chk("arst_valid", 64'(ValidE), 64'd0);
        chk("arst_ready", 64'(ReadyD), 64'd1);
        chk("arst_rd1", RD1E, 64'd0);
        chk_pay("arst_outputs", dout, '0);
        q.delete();
        hold_v = 0;
        @(negedge CLK);
        RST_N = 1;
        ValidD = 1; din = mk(64'h500); ReadyE = 0; FlushE = 0;
        #1 sb_update();
        @(posedge CLK);
        #1;
        chk("first_accept_valid", 64'(ValidE), 64'd1);
        chk("first_accept_pc", PCE, 64'h500);
        for (int i = 0; i < 10000; i++) begin
            p = mk(64'(i + 'h1000) << 2);
            p.rd2 = {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 4; i++) drive(0, '0, 1, 0);
        chk("drained", 64'(ValidE), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC, PCPlus4, RD1, RD2, ImmExt.
REQ-002 SHALL have parameter ACW, default 3: ALUControl width.
REQ-003 SHALL have parameter RAW, default 5: register-address width (Rs1, Rs2, Rd).
REQ-004 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port FlushE  in  1  synchronous flush of all held entries.
REQ-007 SHALL have port ValidD  in  1  decode-stage payload valid.
REQ-008 SHALL have port ReadyD  out  1  stage can accept; driven directly from a flop.
REQ-009 SHALL have ports RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD  in  1 each  decode controls.
REQ-010 SHALL have port ALUControlD  in  ACW  ALU operation.
REQ-011 SHALL have ports PCD, PCPlus4D, RD1D, RD2D, ImmExtD  in  XLEN each  decode data.
REQ-012 SHALL have ports Rs1D, Rs2D, RdD  in  RAW each  register addresses (Rs1/Rs2 carried for forwarding).
REQ-013 SHALL have port ValidE  out  1  execute-stage payload valid.
REQ-014 SHALL have port ReadyE  in  1  execute stage consumes payload.
REQ-015 SHALL have outputs RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE, PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE mirroring the D inputs, same widths.

Function
REQ-016 SHALL hold a main entry M (drives E outputs) and one skid entry S; ValidE = M.valid.
REQ-017 SHALL define accept = ValidD & ReadyD and retire = ValidE & ReadyE.
REQ-018 SHALL implement states EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
REQ-019 SHALL register ReadyD = 1 in EMPTY and ONE, 0 in FULL.
REQ-020 EMPTY: accept -> M<=D, ONE; else hold.
REQ-021 ONE: accept&retire -> M<=D, stay ONE; accept&!retire -> S<=D, FULL; !accept&retire -> EMPTY; neither -> hold.
REQ-022 FULL: retire -> M<=S, ONE; else hold; no accept possible.
REQ-023 SHALL give latency of exactly 1 cycle from accept to ValidE when entering EMPTY->ONE or ONE->ONE; sustained throughput 1 per cycle with ReadyE=1.
REQ-024 SHALL keep all E outputs stable while ValidE=1 and ReadyE=0.
REQ-025 SHALL force RegWriteE, MemWriteE, BranchE to 0 whenever ValidE=0 (bubble cannot commit).
REQ-026 FlushE=1 SHALL, at the edge, invalidate M and S, enter EMPTY, set ReadyD=1, and discard any same-cycle accept or retire transfer; flush has priority over all transitions.
REQ-027 SHALL preserve payload order: S never bypasses M.
REQ-028 SHALL not load data flops except on capture into M or S (no clock gating implied).
REQ-029 SHALL treat all payload as opaque bits; no arithmetic, no width conversion.

Reset
REQ-030 RST_N=0 SHALL asynchronously force state EMPTY, ValidE=0, ReadyD=1, all E outputs 0.
REQ-031 SHALL leave reset synchronously-safe: first accept possible on first rising edge with RST_N=1.
REQ-032 Reset asserted mid-operation (ONE or FULL) SHALL drop all held payloads immediately.

Verification
REQ-033 Streaming: ReadyE=1, ValidD=1 with PCD=0x0,0x4,0x8 on consecutive edges -> PCE=0x0,0x4,0x8 one cycle later each, ReadyD stays 1.
REQ-034 Backpressure: ReadyE=0, push PCD=0x100 then 0x104 -> ValidE=1 PCE=0x100 held, ReadyD=0 after 2nd accept; ReadyE=1 two cycles -> PCE=0x104 then ValidE=0, ReadyD=1.
REQ-035 Flush in FULL with ValidD=1 PCD=0x200 same cycle -> next cycle ValidE=0, RegWriteE=MemWriteE=BranchE=0, ReadyD=1, 0x200 never appears on PCE.
REQ-036 Async reset: drop RST_N between edges while FULL -> ValidE=0, ReadyD=1, RD1E=0 immediately, before next CLK edge.
REQ-037 Parameters XLEN=64, ACW=4: RD1D=0xFFFF_0000_1234_5678, ALUControlD=0xA -> identical values on RD1E, ALUControlE after 1 cycle.
REQ-038 Random ValidD/ReadyE/FlushE for 10k cycles vs scoreboard -> no loss, duplication or reordering except flushed entries.
